icache_data_ctrl: RTL and testbench

//  Sequences and arbitrates the single-port 64-bit x 1024 icache data RAM (1-cycle registered read).

---
 rtl/icache_pkg.sv | 21 ++
 rtl/icache_data_ctrl_if.sv | 40 ++++
 rtl/icache_data_ctrl.sv | 87 ++++++++
 tb/tb_icache_data_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared icache data-path constants, refill FSM encoding and RAM request payload.
package icache_pkg;

  localparam int unsigned ICACHE_ADDR_W     = 10;
  localparam int unsigned ICACHE_WORD_OFF_W = 2;
  localparam int unsigned ICACHE_DATA_W     = 64;
  localparam int unsigned ICACHE_LINE_W     = ICACHE_ADDR_W - ICACHE_WORD_OFF_W;

  localparam logic [ICACHE_WORD_OFF_W-1:0] ICACHE_CNT_MAX = '1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic                     wr;
    logic [ICACHE_ADDR_W-1:0] addr;
    logic [ICACHE_DATA_W-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/icache_data_ctrl_if.sv
// Fetch, refill-beat and data-RAM signals of the icache data controller.
interface icache_data_ctrl_if;
  import icache_pkg::*;

  logic                     fetch_rd_i;
  logic [ICACHE_ADDR_W-1:0] fetch_addr_i;
  logic                     fetch_stall_o;
  logic                     fetch_valid_o;
  logic [ICACHE_DATA_W-1:0] fetch_data_o;

  logic                     refill_start_i;
  logic [ICACHE_LINE_W-1:0] refill_line_i;
  logic                     beat_valid_i;
  logic [ICACHE_DATA_W-1:0] beat_data_i;
  logic                     beat_last_i;
  logic                     abort_i;
  logic                     refill_busy_o;
  logic                     refill_done_o;
  logic                     refill_err_o;

  logic [ICACHE_ADDR_W-1:0] ram_addr_o;
  logic [ICACHE_DATA_W-1:0] ram_wdata_o;
  logic                     ram_wr_o;
  logic [ICACHE_DATA_W-1:0] ram_rdata_i;

  modport slave (
    input  fetch_rd_i, fetch_addr_i, refill_start_i, refill_line_i,
           beat_valid_i, beat_data_i, beat_last_i, abort_i, ram_rdata_i,
    output fetch_stall_o, fetch_valid_o, fetch_data_o, refill_busy_o,
           refill_done_o, refill_err_o, ram_addr_o, ram_wdata_o, ram_wr_o
  );

  modport master (
    output fetch_rd_i, fetch_addr_i, refill_start_i, refill_line_i,
           beat_valid_i, beat_data_i, beat_last_i, abort_i, ram_rdata_i,
    input  fetch_stall_o, fetch_valid_o, fetch_data_o, refill_busy_o,
           refill_done_o, refill_err_o, ram_addr_o, ram_wdata_o, ram_wr_o
  );

endinterface

// File: rtl/icache_data_ctrl.sv
// Arbitrates the single-port icache data RAM between CPU fetch reads and line refill writes.
// Refill owns the port from start until the DONE cycle exits; fetch is stalled meanwhile.
module icache_data_ctrl
  import icache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  icache_data_ctrl_if.slave   bus
);

  logic [1:0]                   state_q, state_d;
  logic [ICACHE_WORD_OFF_W-1:0] cnt_q,   cnt_d;
  logic [ICACHE_LINE_W-1:0]     line_q,  line_d;
  logic                         valid_q, valid_d;
  logic                         err_q,   err_d;
  logic                         stall_c;
  ram_req_t                     req_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next state, beat sequencing and RAM port mux
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    err_d       = 1'b0;
    stall_c     = (state_q != ST_IDLE) | bus.refill_start_i;
    valid_d     = bus.fetch_rd_i & ~stall_c;
    req_c.wr    = 1'b0;
    req_c.addr  = bus.fetch_addr_i;
    req_c.wdata = bus.beat_data_i;

    case (state_q)
      ST_IDLE: begin
        if (bus.refill_start_i) begin
          state_d = ST_FILL;
          line_d  = bus.refill_line_i;
          cnt_d   = '0;
        end
      end
      ST_FILL: begin
        // abort beats a coincident beat: nothing is written
        if (bus.abort_i) begin
          state_d = ST_IDLE;
        end else if (bus.beat_valid_i) begin
          req_c.wr   = 1'b1;
          req_c.addr = {line_q, cnt_q};
          cnt_d      = cnt_q + ICACHE_WORD_OFF_W'(1);
          if (bus.beat_last_i && (cnt_q == ICACHE_CNT_MAX)) begin
            state_d = ST_DONE;
          end else if (bus.beat_last_i || (cnt_q == ICACHE_CNT_MAX)) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.fetch_stall_o = stall_c;
  assign bus.fetch_valid_o = valid_q;
  assign bus.fetch_data_o  = bus.ram_rdata_i;
  assign bus.refill_busy_o = (state_q != ST_IDLE);
  assign bus.refill_done_o = (state_q == ST_DONE);
  assign bus.refill_err_o  = err_q;
  assign bus.ram_addr_o    = req_c.addr;
  assign bus.ram_wdata_o   = req_c.wdata;
  assign bus.ram_wr_o      = req_c.wr;

endmodule

// File: tb/tb_icache_data_ctrl.sv
// Randomized scoreboard bench for icache_data_ctrl with a 1-cycle registered data RAM model.
module tb_icache_data_ctrl;
  import icache_pkg::*;

  localparam int OUT_DONE  = 0;
  localparam int OUT_ERR   = 1;
  localparam int OUT_ABORT = 2;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  icache_data_ctrl_if bus();

  icache_data_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Data RAM model, with a preload port used before the test starts
  logic [63:0] mem [1024];
  logic        pl_we = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [63:0] pl_data = '0;
  logic [63:0] ref_mem [1024];
  exp_t        exp_q [$];

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (bus.ram_wr_o) mem[bus.ram_addr_o] <= bus.ram_wdata_o;
    bus.ram_rdata_i <= mem[bus.ram_addr_o];
  end

  function automatic logic [63:0] rnd64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Fetch monitor: compares every presented read against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.fetch_valid_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL fetch_unexpected: got valid data %h expected no read (cycle %0d)",
                   bus.fetch_data_o, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (bus.fetch_data_o !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL fetch_data: got %h at cycle %0d expected %h at cycle %0d",
                     bus.fetch_data_o, cyc, e.data, e.cyc);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL fetch_missing: got no valid at cycle %0d expected %h", cyc, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.fetch_rd_i     = 1'b0;
    bus.fetch_addr_i   = '0;
    bus.refill_start_i = 1'b0;
    bus.refill_line_i  = '0;
    bus.beat_valid_i   = 1'b0;
    bus.beat_data_i    = '0;
    bus.beat_last_i    = 1'b0;
    bus.abort_i        = 1'b0;
  endtask

  task automatic idle();
    tick();
    clear_inputs();
  endtask

  task automatic push_read(input logic [9:0] a);
    exp_t e;
    e.data = ref_mem[a];
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Issue one fetch in an unstalled cycle; abort is toggled to show it is ignored in IDLE
  task automatic fetch_one(input logic [9:0] a);
    tick();
    clear_inputs();
    bus.fetch_rd_i   = 1'b1;
    bus.fetch_addr_i = a;
    bus.abort_i      = 1'($urandom_range(0, 1));
    push_read(a);
    @(negedge clk);
    chk("fetch_stall", 64'(bus.fetch_stall_o), 64'd0);
  endtask

  task automatic read_line(input logic [7:0] line);
    for (int w = 0; w < 4; w++) fetch_one({line, 2'(w)});
    idle();
  endtask

  // One refill; expected outcome follows from the beat rules, not from the DUT
  task automatic run_refill(input logic [7:0] line, input int last_at, input int abort_at,
                            input int max_gap, input bit hold, input logic [9:0] faddr);
    int          kend;
    int          outcome;
    int          gaps;
    logic [63:0] d;
    logic [9:0]  wa;
    bit          ab;
    kend    = 3;
    outcome = OUT_ERR;
    for (int k = 0; k < 4; k++) begin
      kend = k;
      if (k == abort_at) begin outcome = OUT_ABORT; break; end
      if (k == last_at || k == 3) begin
        outcome = (k == last_at && k == 3) ? OUT_DONE : OUT_ERR;
        break;
      end
    end

    tick();
    clear_inputs();
    bus.refill_start_i = 1'b1;
    bus.refill_line_i  = line;
    bus.fetch_rd_i     = hold;
    bus.fetch_addr_i   = faddr;
    @(negedge clk);
    chk("start_stall", 64'(bus.fetch_stall_o), 64'd1);
    chk("start_busy", 64'(bus.refill_busy_o), 64'd0);

    for (int k = 0; k <= kend; k++) begin
      gaps = $urandom_range(0, max_gap);
      repeat (gaps) begin
        tick();
        bus.beat_valid_i   = 1'b0;
        bus.beat_last_i    = 1'b0;
        bus.refill_start_i = 1'($urandom_range(0, 1));
        bus.refill_line_i  = 8'($urandom);
        @(negedge clk);
        chk("gap_wr", 64'(bus.ram_wr_o), 64'd0);
        chk("gap_stall", 64'(bus.fetch_stall_o), 64'd1);
      end
      tick();
      ab = (outcome == OUT_ABORT) && (k == kend);
      d  = rnd64();
      wa = {line, 2'(k)};
      bus.refill_start_i = 1'b0;
      bus.beat_valid_i   = 1'b1;
      bus.beat_data_i    = d;
      bus.beat_last_i    = (k == last_at);
      bus.abort_i        = ab;
      @(negedge clk);
      chk("beat_wr", 64'(bus.ram_wr_o), ab ? 64'd0 : 64'd1);
      chk("beat_busy", 64'(bus.refill_busy_o), 64'd1);
      chk("beat_stall", 64'(bus.fetch_stall_o), 64'd1);
      chk("beat_done", 64'(bus.refill_done_o), 64'd0);
      chk("beat_err", 64'(bus.refill_err_o), 64'd0);
      if (!ab) begin
        chk("beat_addr", 64'(bus.ram_addr_o), 64'(wa));
        chk("beat_wdata", bus.ram_wdata_o, d);
        ref_mem[wa] = d;
      end
    end

    tick();
    bus.beat_valid_i = 1'b0;
    bus.beat_last_i  = 1'b0;
    bus.abort_i      = 1'b0;
    @(negedge clk);
    if (outcome == OUT_DONE) begin
      chk("done_pulse", 64'(bus.refill_done_o), 64'd1);
      chk("done_busy", 64'(bus.refill_busy_o), 64'd1);
      chk("done_err", 64'(bus.refill_err_o), 64'd0);
      chk("done_stall", 64'(bus.fetch_stall_o), 64'd1);
      tick();
      @(negedge clk);
      chk("post_done", 64'(bus.refill_done_o), 64'd0);
    end else begin
      chk("end_err", 64'(bus.refill_err_o), (outcome == OUT_ERR) ? 64'd1 : 64'd0);
      chk("end_done", 64'(bus.refill_done_o), 64'd0);
    end
    chk("end_busy", 64'(bus.refill_busy_o), 64'd0);
    chk("end_stall", 64'(bus.fetch_stall_o), 64'd0);
    if (hold) push_read(faddr);
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by cycle %0d expected end of test", cyc);
    $fatal(1);
  end

  initial begin
    int          r;
    logic [7:0]  ln;
    logic [63:0] d;
    clear_inputs();

    // Preload RAM and the reference copy while in reset
    for (int i = 0; i < 1024; i++) begin
      @(posedge clk);
      #1;
      d        = rnd64();
      pl_we    = 1'b1;
      pl_addr  = 10'(i);
      pl_data  = d;
      ref_mem[i] = d;
    end
    tick();
    pl_we = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(bus.fetch_valid_o), 64'd0);
    chk("rst_stall", 64'(bus.fetch_stall_o), 64'd0);
    chk("rst_busy", 64'(bus.refill_busy_o), 64'd0);
    chk("rst_done", 64'(bus.refill_done_o), 64'd0);
    chk("rst_err", 64'(bus.refill_err_o), 64'd0);
    chk("rst_wr", 64'(bus.ram_wr_o), 64'd0);
    tick();
    rst_n = 1'b1;
    idle();

    // Back-to-back fetch
    fetch_one(10'h004);
    fetch_one(10'h005);
    idle();

    // Clean refill of line 0x12, contiguous beats
    run_refill(8'h12, 3, -1, 0, 1'b0, '0);
    read_line(8'h12);
    // Refill with gaps and a held fetch of 0x049
    run_refill(8'h12, 3, -1, 2, 1'b1, 10'h049);
    idle();
    // Early last -> error after two beats
    run_refill(8'h20, 1, -1, 1, 1'b0, '0);
    read_line(8'h20);
    // Abort on the third beat
    run_refill(8'h21, 3, 2, 1, 1'b0, '0);
    read_line(8'h21);
    // Fourth beat without last -> error
    run_refill(8'h22, 99, -1, 0, 1'b1, 10'h088);
    read_line(8'h22);

    // Reset in the middle of a fill
    tick();
    clear_inputs();
    bus.refill_start_i = 1'b1;
    bus.refill_line_i  = 8'h30;
    for (int k = 0; k < 2; k++) begin
      tick();
      d = rnd64();
      bus.refill_start_i = 1'b0;
      bus.beat_valid_i   = 1'b1;
      bus.beat_data_i    = d;
      ref_mem[{8'h30, 2'(k)}] = d;
    end
    tick();
    bus.beat_data_i = rnd64();
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_wr", 64'(bus.ram_wr_o), 64'd0);
    chk("midrst_busy", 64'(bus.refill_busy_o), 64'd0);
    chk("midrst_done", 64'(bus.refill_done_o), 64'd0);
    chk("midrst_err", 64'(bus.refill_err_o), 64'd0);
    chk("midrst_valid", 64'(bus.fetch_valid_o), 64'd0);
    chk("midrst_stall", 64'(bus.fetch_stall_o), 64'd0);
    tick();
    clear_inputs();
    rst_n = 1'b1;
    run_refill(8'h30, 3, -1, 1, 1'b0, '0);
    read_line(8'h30);

    // Randomized mix of fetch bursts and refills
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(1, 4);
        for (int j = 0; j < r; j++) fetch_one(10'($urandom));
        idle();
      end else begin
        ln = 8'($urandom);
        r  = $urandom_range(0, 9);
        if (r < 6)       run_refill(ln, 3, -1, 2, 1'($urandom_range(0, 1)), 10'($urandom));
        else if (r == 6) run_refill(ln, $urandom_range(0, 2), -1, 2, 1'b0, '0);
        else if (r == 7) run_refill(ln, 99, -1, 2, 1'b0, '0);
        else             run_refill(ln, 3, $urandom_range(0, 3), 2, 1'b0, '0);
        read_line(ln);
      end
    end

    repeat (4) idle();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
